sha256_w_expander: RTL and testbench

Parametrised, streaming SHA-256 message-schedule expander for the double-SHA256 mining datapath. It loads one 512-bit block and emits W0..W63 in order, WPC words per beat, under a valid/ready handshake. An optional padding mode regenerates the fixed padding of the 80-byte-header second block internally. It feeds the round pipeline and replaces the per-stage single-word schedule slices.

---
 rtl/sha256_w_expander.sv | 176 +++++++++++++++++
 tb/tb_sha256_w_expander.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_w_expander.sv
`timescale 1ns/1ps
// sha256_w_expander
//
// Streaming SHA-256 message-schedule expander. A 512-bit block is loaded
// into a 16-word sliding window. W0..W63 are then emitted in order, WPC words
// per beat. Each accepted beat shifts the window by WPC and appends WPC newly
// expanded words. Later words in a beat chain combinationally on earlier words
// of the same beat. With PAD_MODE=1 the fixed padding words of the 80-byte
// header's second block replace block_in[383:0] at load time.
//
// Handshake: a beat transfers on a rising edge where w_valid=1 and w_ready=1.
// While w_valid=1 and w_ready=0, w_out, w_idx and the window hold steady and
// w_valid stays high. w_valid never drops until its beat has transferred.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   load request, honoured only while busy=0
//   block_in  in   512-bit block, W0 in [511:480] down to W15 in [31:0]
//   w_ready   in   consumer accepts the current beat
//   w_valid   out  w_out/w_idx carry a valid beat
//   w_out     out  W[w_idx]..W[w_idx+WPC-1], lowest index in the MSBs
//   w_idx     out  index of the first word in w_out
//   busy      out  a block is loaded and not yet fully emitted
//   done      out  one-cycle pulse after the final beat is accepted
//   state_dbg out  FSM state (0=IDLE, 1=RUN)
module sha256_w_expander #(
    parameter int WPC      = 1,
    parameter bit PAD_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [511:0]      block_in,
    input  logic              w_ready,
    output logic              w_valid,
    output logic [32*WPC-1:0] w_out,
    output logic [5:0]        w_idx,
    output logic              busy,
    output logic              done,
    output logic              state_dbg
);

    generate
        if (WPC != 1 && WPC != 2 && WPC != 4) begin : g_bad_wpc
            $error("sha256_w_expander: WPC must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(64 - WPC);
    localparam logic [5:0] IDX_STEP = 6'(WPC);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] win_q [16];
    logic [5:0]  idx_q;
    logic        done_q;
    logic        done_d;
    logic        load;
    logic        advance;

    // Window extended by the WPC words produced this beat. ext[16+k] is
    // W[idx+16+k]. For k>=2 its W[t-2] term is ext[14+k], which is a word
    // produced earlier in the same beat.
    logic [31:0] ext [16+WPC];
    logic [31:0] load_w [16];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ext[i] = win_q[i];
        end
        for (int k = 0; k < WPC; k++) begin
            ext[16+k] = sig1(ext[k+14]) + ext[k+9] + sig0(ext[k+1]) + ext[k];
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            load_w[i] = block_in[511-32*i -: 32];
        end
        if (PAD_MODE) begin
            load_w[4] = 32'h8000_0000;
            for (int i = 5; i < 15; i++) begin
                load_w[i] = 32'h0000_0000;
            end
            load_w[15] = 32'h0000_0280;
        end
    end

    // Next-state and control.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (w_ready) begin
                    advance = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 6'd0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                idx_q <= 6'd0;
                for (int i = 0; i < 16; i++) begin
                    win_q[i] <= load_w[i];
                end
            end else if (advance) begin
                // Wraps to 0 only on the final beat, when the block is over.
                idx_q <= idx_q + IDX_STEP;
                for (int i = 0; i < 16; i++) begin
                    win_q[i] <= ext[i+WPC];
                end
            end
        end
    end

    // The window keeps leftover words after the last beat, so the lanes
    // are gated to present zeros outside RUN.
    always_comb begin
        w_out = '0;
        if (state_q == RUN) begin
            for (int k = 0; k < WPC; k++) begin
                w_out[32*(WPC-k)-1 -: 32] = win_q[k];
            end
        end
    end

    assign w_valid   = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign w_idx     = idx_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sha256_w_expander.sv
`timescale 1ns/1ps
module tb_sha256_w_expander;

    // Instance 0: WPC=1, 1: WPC=2, 2: WPC=4, 3: WPC=1 with PAD_MODE=1.
    logic         clk;
    logic         rst;
    logic         start_s [4];
    logic [511:0] block_s [4];
    logic         ready_s [4];
    logic         valid_s [4];
    logic [5:0]   idx_s   [4];
    logic         busy_s  [4];
    logic         done_s  [4];
    logic         state_s [4];
    logic [31:0]  wo0;
    logic [63:0]  wo1;
    logic [127:0] wo2;
    logic [31:0]  wo3;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model [64];
    logic [31:0] got   [64];
    logic [31:0] exp_q [$];

    sha256_w_expander #(.WPC(1), .PAD_MODE(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .block_in(block_s[0]),
        .w_ready(ready_s[0]), .w_valid(valid_s[0]), .w_out(wo0), .w_idx(idx_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .state_dbg(state_s[0]));

    sha256_w_expander #(.WPC(2), .PAD_MODE(1'b0)) u_w2 (
        .clk(clk), .rst(rst), .start(start_s[1]), .block_in(block_s[1]),
        .w_ready(ready_s[1]), .w_valid(valid_s[1]), .w_out(wo1), .w_idx(idx_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .state_dbg(state_s[1]));

    sha256_w_expander #(.WPC(4), .PAD_MODE(1'b0)) u_w4 (
        .clk(clk), .rst(rst), .start(start_s[2]), .block_in(block_s[2]),
        .w_ready(ready_s[2]), .w_valid(valid_s[2]), .w_out(wo2), .w_idx(idx_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .state_dbg(state_s[2]));

    sha256_w_expander #(.WPC(1), .PAD_MODE(1'b1)) u_pad (
        .clk(clk), .rst(rst), .start(start_s[3]), .block_in(block_s[3]),
        .w_ready(ready_s[3]), .w_valid(valid_s[3]), .w_out(wo3), .w_idx(idx_s[3]),
        .busy(busy_s[3]), .done(done_s[3]), .state_dbg(state_s[3]));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // FIPS 180-4 message schedule, computed over the whole 64-word array.
    function automatic void build_model(input logic [511:0] blk, input bit pad);
        logic [31:0] s0;
        logic [31:0] s1;
        for (int t = 0; t < 16; t++) model[t] = blk[511-32*t -: 32];
        if (pad) begin
            model[4] = 32'h8000_0000;
            for (int t = 5; t < 15; t++) model[t] = 32'h0;
            model[15] = 32'h0000_0280;
        end
        for (int t = 16; t < 64; t++) begin
            s0 = ror(model[t-15], 7) ^ ror(model[t-15], 18) ^ (model[t-15] >> 3);
            s1 = ror(model[t-2], 17) ^ ror(model[t-2], 19) ^ (model[t-2] >> 10);
            model[t] = s1 + model[t-7] + s0 + model[t-16];
        end
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    function automatic int wpc_of(input int d);
        case (d)
            1:       return 2;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] lane(input int d, input int k);
        case (d)
            0:       return wo0;
            1:       return wo1[63-32*k -: 32];
            2:       return wo2[127-32*k -: 32];
            default: return wo3;
        endcase
    endfunction

    // ---------------- driver + scoreboard ----------------
    // Starts blk on instance d at the current negedge and consumes the stream
    // with ready asserted pct% of the time. busy_beat>=0 pulses start with
    // `other` during that beat. rst_idx>=0 returns early (aborted=1) at the
    // negedge where w_idx==rst_idx. Ends at the negedge where done is visible,
    // so a following call issues its start in the done cycle.
    task automatic run_stream(input int d, input logic [511:0] blk, input bit pad,
                              input int pct, input int busy_beat,
                              input logic [511:0] other, input int rst_idx,
                              output bit aborted);
        int          wpc;
        int          nbeats;
        int          beat;
        int          cyc;
        int          idx_e;
        bit          prev_acc;
        bit          r;
        logic [31:0] prev_w [4];
        logic [31:0] w;
        wpc      = wpc_of(d);
        nbeats   = 64 / wpc;
        beat     = 0;
        cyc      = 0;
        idx_e    = 0;
        prev_acc = 1'b1;
        aborted  = 1'b0;
        build_model(blk, pad);
        exp_q.delete();
        for (int t = 0; t < 64; t++) exp_q.push_back(model[t]);

        start_s[d] = 1'b1;
        block_s[d] = blk;
        ready_s[d] = 1'b0;
        @(negedge clk);
        start_s[d] = 1'b0;
        block_s[d] = rand_block();

        n_checks++;
        if (done_s[d] !== 1'b0)
            $display("FAIL done_after_start inst=%0d got=%b exp=0", d, done_s[d]);
        else n_pass++;

        while (beat < nbeats && cyc < 4000) begin
            n_checks++;
            if (valid_s[d] !== 1'b1)
                $display("FAIL w_valid inst=%0d beat=%0d got=%b exp=1", d, beat, valid_s[d]);
            else n_pass++;
            n_checks++;
            if (idx_s[d] !== 6'(idx_e))
                $display("FAIL w_idx inst=%0d got=%0d exp=%0d", d, idx_s[d], idx_e);
            else n_pass++;
            for (int k = 0; k < wpc; k++) begin
                w = lane(d, k);
                got[idx_e+k] = w;
                n_checks++;
                if (w !== exp_q[k])
                    $display("FAIL word inst=%0d W%0d got=%h exp=%h", d, idx_e + k, w, exp_q[k]);
                else n_pass++;
                if (!prev_acc) begin
                    n_checks++;
                    if (w !== prev_w[k])
                        $display("FAIL stall_hold inst=%0d lane=%0d got=%h exp=%h", d, k, w, prev_w[k]);
                    else n_pass++;
                end
                prev_w[k] = w;
            end
            if (rst_idx >= 0 && idx_e == rst_idx) begin
                aborted = 1'b1;
                ready_s[d] = 1'b0;
                return;
            end
            if (busy_beat >= 0 && beat == busy_beat && cyc < 4000 && start_s[d] == 1'b0 && prev_acc) begin
                start_s[d] = 1'b1;
                block_s[d] = other;
            end else begin
                start_s[d] = 1'b0;
            end
            r = ($urandom_range(0, 99) < pct);
            ready_s[d] = r;
            @(negedge clk);
            cyc++;
            if (r) begin
                for (int k = 0; k < wpc; k++) void'(exp_q.pop_front());
                idx_e += wpc;
                beat++;
            end
            prev_acc = r;
        end
        start_s[d] = 1'b0;
        ready_s[d] = 1'b0;
        if (cyc >= 4000) begin
            n_checks++;
            $display("FAIL timeout inst=%0d beats=%0d exp=%0d", d, beat, nbeats);
        end
        n_checks++;
        if (done_s[d] !== 1'b1) $display("FAIL done_pulse inst=%0d got=%b exp=1", d, done_s[d]);
        else n_pass++;
        n_checks++;
        if (busy_s[d] !== 1'b0) $display("FAIL busy_end inst=%0d got=%b exp=0", d, busy_s[d]);
        else n_pass++;
        n_checks++;
        if (valid_s[d] !== 1'b0) $display("FAIL valid_end inst=%0d got=%b exp=0", d, valid_s[d]);
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            start_s[d] = 1'b0;
            ready_s[d] = 1'b0;
            block_s[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if ({valid_s[d], busy_s[d], done_s[d], state_s[d]} !== 4'b0000)
                $display("FAIL reset_flags inst=%0d got=%b exp=0000", d,
                         {valid_s[d], busy_s[d], done_s[d], state_s[d]});
            else n_pass++;
            n_checks++;
            if (idx_s[d] !== 6'd0) $display("FAIL reset_idx inst=%0d got=%0d exp=0", d, idx_s[d]);
            else n_pass++;
            for (int k = 0; k < wpc_of(d); k++) begin
                n_checks++;
                if (lane(d, k) !== 32'h0)
                    $display("FAIL reset_wout inst=%0d lane=%0d got=%h exp=0", d, k, lane(d, k));
                else n_pass++;
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [511:0] abc_block();
        logic [511:0] b;
        b = '0;
        b[511:480] = 32'h6162_6380;
        b[31:0]    = 32'h0000_0018;
        return b;
    endfunction

    task automatic test_abc_wpc1();
        bit ab;
        run_stream(0, abc_block(), 1'b0, 100, -1, '0, -1, ab);
        n_checks++;
        if (got[16] !== 32'h6162_6380) $display("FAIL abc_w16 got=%h exp=61626380", got[16]);
        else n_pass++;
        n_checks++;
        if (got[17] !== 32'h000F_0000) $display("FAIL abc_w17 got=%h exp=000f0000", got[17]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done_s[0] !== 1'b0) $display("FAIL done_single got=%b exp=0", done_s[0]);
        else n_pass++;
    endtask

    task automatic test_abc_wpc4();
        bit ab;
        run_stream(2, abc_block(), 1'b0, 100, -1, '0, -1, ab);
        n_checks++;
        if (got[0] !== 32'h6162_6380) $display("FAIL abc4_w0 got=%h exp=61626380", got[0]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done_s[2] !== 1'b0) $display("FAIL done_single4 got=%b exp=0", done_s[2]);
        else n_pass++;
    endtask

    task automatic test_start_in_done();
        bit ab;
        run_stream(2, rand_block(), 1'b0, 100, -1, '0, -1, ab);
        // Next start lands in the done cycle; its W0 must follow one cycle later.
        run_stream(2, rand_block(), 1'b0, 100, -1, '0, -1, ab);
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        bit ab;
        run_stream(0, rand_block(), 1'b0, 100, 10, rand_block(), -1, ab);
        @(negedge clk);
        n_checks++;
        if (valid_s[0] !== 1'b0) $display("FAIL busy_start_leak got=%b exp=0", valid_s[0]);
        else n_pass++;
    endtask

    task automatic test_pad();
        bit ab;
        logic [511:0] b;
        b = rand_block();
        b[383:0] = {384{1'b1}};
        run_stream(3, b, 1'b1, 100, -1, '0, -1, ab);
        n_checks++;
        if (got[4] !== 32'h8000_0000) $display("FAIL pad_w4 got=%h exp=80000000", got[4]);
        else n_pass++;
        for (int t = 5; t < 15; t++) begin
            n_checks++;
            if (got[t] !== 32'h0) $display("FAIL pad_w%0d got=%h exp=00000000", t, got[t]);
            else n_pass++;
        end
        n_checks++;
        if (got[15] !== 32'h0000_0280) $display("FAIL pad_w15 got=%h exp=00000280", got[15]);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ab;
        for (int i = 0; i < 100; i++) begin
            run_stream(1, rand_block(), 1'b0, 50, -1, '0, -1, ab);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        bit ab;
        run_stream(0, rand_block(), 1'b0, 70, -1, '0, 20, ab);
        n_checks++;
        if (ab !== 1'b1) $display("FAIL rst_reach_idx20 got=%b exp=1", ab);
        else n_pass++;
        rst = 1'b1;
        start_s[0] = 1'b1;
        block_s[0] = rand_block();
        @(negedge clk);
        n_checks++;
        if ({valid_s[0], busy_s[0], done_s[0], state_s[0]} !== 4'b0000)
            $display("FAIL rst_mid_flags got=%b exp=0000", {valid_s[0], busy_s[0], done_s[0], state_s[0]});
        else n_pass++;
        n_checks++;
        if (idx_s[0] !== 6'd0 || wo0 !== 32'h0)
            $display("FAIL rst_mid_outs got=%0d/%h exp=0/00000000", idx_s[0], wo0);
        else n_pass++;
        rst = 1'b0;
        start_s[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid_s[0] !== 1'b0) $display("FAIL rst_start_lost got=%b exp=0", valid_s[0]);
        else n_pass++;
        run_stream(0, rand_block(), 1'b0, 100, -1, '0, -1, ab);
        @(negedge clk);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_abc_wpc1();
        test_abc_wpc4();
        test_start_in_done();
        test_start_while_busy();
        test_pad();
        test_backpressure();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
